sd_crc7: RTL and testbench
==========================

Name: sd_crc7

Overview:
- Bit-serial CRC-7 generator/checker for the SD-card command line; polynomial x^7 + x^3 + 1.
- The command serial host feeds one bit per SD clock while enabled:
  - command bits 1..40 when transmitting, so the CRC is ready for bits 41..47;
  - received response bits when checking.
- The host reads the 7-bit remainder directly.
- Clearing is done via reset between frames.

Parameters:
- CRC_WIDTH, 7, remainder width in bits.
- POLY, 7'h09, feedback taps excluding the x^CRC_WIDTH term; bit i set means x^i is present (0x09 = x^3 + 1).

Ports:
- CLK  input  1  SD clock; all state changes on the rising edge.
- RST_N  input  1  synchronous, active-low reset/clear of the remainder.
- BITVAL  input  1  serial data bit, MSB of the frame first.
- ENABLE  input  1  when high, BITVAL is absorbed on this edge.
- CRC  output  CRC_WIDTH  current remainder, driven straight from the register.

Behaviour:
- Reset: synchronous, active-low; reset is sampled on the CLK rising edge only.
  - On an edge with RST_N=0: CRC <= 0, regardless of ENABLE or BITVAL.
  - Reset has priority over ENABLE.
  - Reset asserted mid-frame discards the partial remainder.
- Update on an edge with RST_N=1 and ENABLE=1:
  - fb = BITVAL XOR CRC[CRC_WIDTH-1].
  - For i = CRC_WIDTH-1 down to 1: CRC[i] <= CRC[i-1] XOR (fb AND POLY[i]).
  - CRC[0] <= fb AND POLY[0].
  - With the defaults this is:
    - CRC[6] <= CRC[5], CRC[5] <= CRC[4], CRC[4] <= CRC[3];
    - CRC[3] <= CRC[2]^fb;
    - CRC[2] <= CRC[1], CRC[1] <= CRC[0];
    - CRC[0] <= fb.
- Hold: RST_N=1 and ENABLE=0 keeps CRC unchanged for any number of cycles, and BITVAL is ignored.
- Latency:
  - CRC reflects all bits absorbed up to and including the previous edge.
  - No combinational path from BITVAL or ENABLE to CRC.
- No augmentation: after the last message bit, CRC equals the SD CRC7 field. The transmitted CRC byte is {CRC, 1'b1}.
- Checker use: after absorbing message bits, compare CRC with the received 7 CRC bits. Alternatively, absorb message plus CRC bits, which yields 0 when the frame is valid.
- Power-up value is undefined until the first reset edge.
- X on BITVAL while ENABLE=0 must not corrupt state.

Decomposition:
- Shared package sd_pkg holds:
  - localparam SD_CRC7_WIDTH = 7;
  - localparam SD_CRC7_POLY = 7'h09;
  - the 48-bit command frame size.
- No sub-module; a single register plus a generate loop over the taps.

Test Plan:
- Reset/single bit: RST_N=0 for 1 edge -> CRC=0x00. Then ENABLE=1, BITVAL=1 for 1 edge -> CRC=0x09. Then one BITVAL=0 enabled edge -> CRC=0x12.
- CMD0: reset, shift 40 bits 0x40_00000000 MSB-first with ENABLE=1 -> CRC=0x4A (frame byte 0x95).
- CMD8 and CMD17:
  - reset, shift 0x48_000001AA -> CRC=0x43 (byte 0x87);
  - reset, shift 0x51_00000000 -> CRC=0x2A (byte 0x55).
- Hold: during a CMD0 shift, insert random ENABLE=0 gaps with random BITVAL -> CRC unchanged across each gap; final CRC still 0x4A.
- Self-check: shift 0x40_00000000 followed by the 7 bits of 0x4A -> CRC=0x00. Flip any single message bit -> CRC nonzero.
- Reset priority: mid-frame, assert RST_N=0 with ENABLE=1 and BITVAL=1 -> CRC=0x00 on that edge. A subsequent full CMD8 shift yields 0x43.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared SD command-line constants for the CRC-7 block
package sd_pkg;
    localparam int SD_CRC7_WIDTH = 7;
    localparam logic [SD_CRC7_WIDTH-1:0] SD_CRC7_POLY = 7'h09;
    localparam int SD_CMD_FRAME_BITS = 48;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: bit-serial CRC-7 generator/checker for the SD command line
module sd_crc7
    import sd_pkg::*;
#(
    parameter int CRC_WIDTH = SD_CRC7_WIDTH,
    parameter logic [CRC_WIDTH-1:0] POLY = SD_CRC7_POLY
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BITVAL,
    input  logic                 ENABLE,
    output logic [CRC_WIDTH-1:0] CRC
);
    logic [CRC_WIDTH-1:0] r_crc;
    logic [CRC_WIDTH-1:0] w_next;
    logic                 w_fb;

    assign w_fb      = BITVAL ^ r_crc[CRC_WIDTH-1];
    assign w_next[0] = w_fb & POLY[0];

    for (genvar i = 1; i < CRC_WIDTH; i++) begin : g_tap
        assign w_next[i] = r_crc[i-1] ^ (w_fb & POLY[i]);
    end

    // clear on reset, otherwise absorb one bit per enabled edge
    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_crc <= '0;
        else if (ENABLE)
            r_crc <= w_next;
    end

    assign CRC = r_crc;
endmodule

// File: tb/tb_sd_crc7.sv
// tb_sd_crc7: randomized self-checking bench against a long-division CRC model
module tb_sd_crc7;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       BITVAL = 1'b0;
    logic       ENABLE = 1'b0;
    logic [6:0] CRC;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    localparam logic [63:0] CMD0  = 64'h40_0000_0000;
    localparam logic [63:0] CMD8  = 64'h48_0000_01AA;
    localparam logic [63:0] CMD17 = 64'h51_0000_0000;

    sd_crc7 dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BITVAL (BITVAL),
        .ENABLE (ENABLE),
        .CRC    (CRC)
    );

    always #5 CLK = ~CLK;

    // remainder of M(x)*x^7 divided by x^7+x^3+1, by polynomial long division
    function automatic logic [6:0] ref_crc(input logic [63:0] m, input int n);
        logic [63:0] v;
        v = m << 7;
        for (int i = n + 6; i >= 7; i--)
            if (v[i]) v = v ^ (64'h89 << (i - 7));
        return v[6:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N  = 1'b0;
        ENABLE = 1'($urandom);
        BITVAL = 1'($urandom);
        tick();
        RST_N  = 1'b1;
        ENABLE = 1'b0;
    endtask

    task automatic shift_bit(input logic b);
        ENABLE = 1'b1;
        BITVAL = b;
        tick();
        ENABLE = 1'b0;
        BITVAL = 1'($urandom);
    endtask

    task automatic shift_msg(input logic [63:0] m, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(m[i]);
    endtask

    task automatic test_reset();
        shift_bit(1'b1);
        shift_bit(1'b1);
        do_reset();
        total_cnt++;
        if (CRC !== 7'h00) $display("FAIL reset: CRC=%h expected=00", CRC);
        else pass_cnt++;
    endtask

    task automatic test_single_bit();
        do_reset();
        shift_bit(1'b1);
        total_cnt++;
        if (CRC !== 7'h09) $display("FAIL single_bit1: CRC=%h expected=09", CRC);
        else pass_cnt++;
        shift_bit(1'b0);
        total_cnt++;
        if (CRC !== 7'h12) $display("FAIL single_bit0: CRC=%h expected=12", CRC);
        else pass_cnt++;
    endtask

    task automatic test_commands();
        logic [63:0] cmds [3] = '{CMD0, CMD8, CMD17};
        logic [6:0]  gold [3] = '{7'h4A, 7'h43, 7'h2A};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            shift_msg(cmds[k], 40);
            total_cnt++;
            if (CRC !== gold[k] || CRC !== ref_crc(cmds[k], 40))
                $display("FAIL command%0d: CRC=%h expected=%h", k, CRC, gold[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        logic [6:0] saved;
        do_reset();
        for (int i = 39; i >= 0; i--) begin
            shift_bit(CMD0[i]);
            saved = CRC;
            for (int g = $urandom_range(1, 3); g > 0; g--) begin
                ENABLE = 1'b0;
                BITVAL = 1'($urandom);
                tick();
            end
            total_cnt++;
            if (CRC !== saved) $display("FAIL hold_bit%0d: CRC=%h expected=%h", i, CRC, saved);
            else pass_cnt++;
        end
        total_cnt++;
        if (CRC !== 7'h4A) $display("FAIL hold_final: CRC=%h expected=4a", CRC);
        else pass_cnt++;
    endtask

    task automatic test_self_check();
        logic [63:0] frame;
        logic [63:0] bad;
        frame = {CMD0[56:0], 7'h4A};
        do_reset();
        shift_msg(frame, 47);
        total_cnt++;
        if (CRC !== 7'h00) $display("FAIL self_check: CRC=%h expected=00", CRC);
        else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            int pos;
            pos = $urandom_range(7, 46);
            bad = frame ^ (64'h1 << pos);
            do_reset();
            shift_msg(bad, 47);
            total_cnt++;
            if (CRC === 7'h00 || CRC !== ref_crc(bad, 47))
                $display("FAIL flip_bit%0d: CRC=%h expected=%h nonzero", pos, CRC, ref_crc(bad, 47));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        shift_msg(CMD8 >> 20, 20);
        RST_N  = 1'b0;
        ENABLE = 1'b1;
        BITVAL = 1'b1;
        tick();
        RST_N  = 1'b1;
        ENABLE = 1'b0;
        total_cnt++;
        if (CRC !== 7'h00) $display("FAIL reset_priority: CRC=%h expected=00", CRC);
        else pass_cnt++;
        shift_msg(CMD8, 40);
        total_cnt++;
        if (CRC !== 7'h43) $display("FAIL after_reset_cmd8: CRC=%h expected=43", CRC);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            logic [63:0] m;
            int          n;
            n = $urandom_range(1, 57);
            m = {$urandom, $urandom} & ((64'h1 << n) - 64'h1);
            do_reset();
            shift_msg(m, n);
            total_cnt++;
            if (CRC !== ref_crc(m, n))
                $display("FAIL random%0d n=%0d: CRC=%h expected=%h", k, n, CRC, ref_crc(m, n));
            else pass_cnt++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_bit();
        test_commands();
        test_hold();
        test_self_check();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
